// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector_param
//  Brief    : Parametrised Moore serial sequence detector with KMP fallback,
//             selectable overlapping/non-overlapping search, one-cycle
//             detection pulse, synchronous search restart and an optional
//             saturating match counter (enabled by macro SEQ_DET_CNT_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter bit                   OVERLAP   = 1'b1,
  parameter int                   CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             valid,
  input  logic             clr,
  output logic             seq_det,
  output logic             det_pulse,
  output logic [CNT_W-1:0] det_count
);

  // State is the number of pattern bits matched so far; PATTERN_W means MATCH.
  localparam int c_STATE_W = $clog2(PATTERN_W + 1);

  typedef logic [c_STATE_W-1:0] state_t;

  localparam state_t c_ST_EMPTY = '0;
  localparam state_t c_ST_MATCH = state_t'(PATTERN_W);

  state_t r_state;
  state_t w_next_state;
  logic   w_hit;
  logic   r_pulse;

  // Pattern bit in reception order (index 0 is the first bit received).
  function automatic logic f_pat_bit(input int idx);
    logic [PATTERN_W-1:0] pat;
    pat = PATTERN;
    if (idx >= 0 && idx < PATTERN_W) begin
      return pat[PATTERN_W-1-idx];
    end
    return 1'b0;
  endfunction

  // Longest prefix of PATTERN that is a suffix of (first k pattern bits, b).
  // When b extends the match this naturally yields k+1; otherwise it is the
  // KMP fallback. Loops are fixed-bound so the logic unrolls at elaboration.
  function automatic state_t f_advance(input int k, input logic b);
    int   best;
    int   idx;
    logic ok;
    logic s_bit;
    best = 0;
    for (int l = 1; l <= PATTERN_W; l++) begin
      if (l <= k + 1) begin
        ok = 1'b1;
        for (int j = 0; j < PATTERN_W; j++) begin
          if (j < l) begin
            idx   = k + 1 - l + j;
            s_bit = (idx == k) ? b : f_pat_bit(idx);
            if (f_pat_bit(j) != s_bit) begin
              ok = 1'b0;
            end
          end
        end
        if (ok) begin
          best = l;
        end
      end
    end
    return state_t'(best);
  endfunction

  // State register: matched-bit count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: clr beats valid; idle cycles hold the state.
  always_comb begin
    w_next_state = r_state;
    w_hit        = 1'b0;
    if (clr) begin
      w_next_state = c_ST_EMPTY;
    end else if (valid) begin
      if (r_state == c_ST_MATCH && !OVERLAP) begin
        w_next_state = (din == f_pat_bit(0)) ? state_t'(1) : c_ST_EMPTY;
      end else begin
        w_next_state = f_advance(int'(r_state), din);
      end
      // A completed match is any valid sample that lands in MATCH. For
      // self-overlapping patterns such as 1111 a MATCH->MATCH step is a new
      // match and must still pulse.
      w_hit = (w_next_state == c_ST_MATCH);
    end
  end

  // Detection pulse, registered alongside the state so it aligns with seq_det.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_hit;
    end
  end

  assign seq_det   = (r_state == c_ST_MATCH);
  assign det_pulse = r_pulse;

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] r_count;

  // Saturating match counter; updates on the same edge that raises det_pulse
  // and is cleared only by rst (clr restarts the search, not the statistics).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_hit && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign det_count = r_count;
`else
  assign det_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detector_param
//  Brief    : Scoreboard bench for seq_detector_param. Four DUT instances
//             cover the default pattern, non-overlap mode, a 2-bit saturating
//             counter and a 5-bit pattern. Counter expectations collapse to 0
//             when SEQ_DET_CNT_EN is not defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

`ifdef SEQ_DET_CNT_EN
  localparam bit c_CNT_ON = 1'b1;
`else
  localparam bit c_CNT_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  logic din_a   [4];
  logic valid_a [4];
  logic clr_a   [4];

  logic        w_det   [4];
  logic        w_pulse [4];
  logic [31:0] w_cnt   [4];

  logic [7:0] w_cnt0;
  logic [7:0] w_cnt1;
  logic [1:0] w_cnt2;
  logic [7:0] w_cnt3;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int    id;
    logic  det;
    logic  pulse;
    int    cnt;
    string name;
  } exp_t;

  exp_t q[$];

  // Default: 1011, overlapping.
  seq_detector_param u_dut0 (
    .clk(clk), .rst(rst), .din(din_a[0]), .valid(valid_a[0]), .clr(clr_a[0]),
    .seq_det(w_det[0]), .det_pulse(w_pulse[0]), .det_count(w_cnt0)
  );

  // 1011, non-overlapping.
  seq_detector_param #(.OVERLAP(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .din(din_a[1]), .valid(valid_a[1]), .clr(clr_a[1]),
    .seq_det(w_det[1]), .det_pulse(w_pulse[1]), .det_count(w_cnt1)
  );

  // 1011, overlapping, 2-bit counter for saturation.
  seq_detector_param #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .din(din_a[2]), .valid(valid_a[2]), .clr(clr_a[2]),
    .seq_det(w_det[2]), .det_pulse(w_pulse[2]), .det_count(w_cnt2)
  );

  // 11011, overlapping.
  seq_detector_param #(.PATTERN_W(5), .PATTERN(5'b11011)) u_dut3 (
    .clk(clk), .rst(rst), .din(din_a[3]), .valid(valid_a[3]), .clr(clr_a[3]),
    .seq_det(w_det[3]), .det_pulse(w_pulse[3]), .det_count(w_cnt3)
  );

  assign w_cnt[0] = {24'd0, w_cnt0};
  assign w_cnt[1] = {24'd0, w_cnt1};
  assign w_cnt[2] = {30'd0, w_cnt2};
  assign w_cnt[3] = {24'd0, w_cnt3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one output sample per cycle, 1 time unit after the active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (w_det[e.id] !== e.det || w_pulse[e.id] !== e.pulse ||
            w_cnt[e.id] !== e.cnt) begin
          n_errors++;
          $display("FAIL %s dut%0d: got det=%b pulse=%b cnt=%0d, expected det=%b pulse=%b cnt=%0d",
                   e.name, e.id, w_det[e.id], w_pulse[e.id], w_cnt[e.id],
                   e.det, e.pulse, e.cnt);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    for (int i = 0; i < 4; i++) begin
      din_a[i]   = 1'b0;
      valid_a[i] = 1'b0;
      clr_a[i]   = 1'b0;
    end
  endtask

  // Apply one cycle of stimulus to one DUT and queue the post-edge outputs.
  task automatic step(input int id, input logic d, input logic v, input logic c,
                      input logic e_det, input logic e_pul, input int e_cnt,
                      input string nm);
    exp_t e;
    @(negedge clk);
    idle_inputs();
    din_a[id]   = d;
    valid_a[id] = v;
    clr_a[id]   = c;
    e.id    = id;
    e.det   = e_det;
    e.pulse = e_pul;
    e.cnt   = c_CNT_ON ? e_cnt : 0;
    e.name  = nm;
    q.push_back(e);
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Assert rst mid-cycle and check dut0 outputs drop before any clock edge.
  task automatic async_reset_check(input string nm);
    @(negedge clk);
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (w_det[0] !== 1'b0 || w_pulse[0] !== 1'b0 || w_cnt[0] !== 0) begin
      n_errors++;
      $display("FAIL %s: got det=%b pulse=%b cnt=%0d, expected all 0",
               nm, w_det[0], w_pulse[0], w_cnt[0]);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] bits16;
    logic [15:0] dets16;
    logic [7:0]  bits8;
    logic [7:0]  dets8;
    int          cnt;

    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state of every instance.
    for (int i = 0; i < 4; i++) step(i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "reset_state");

    // Overlapping 1011 on stream 1011011: matches after bits 4 and 7.
    step(0, 1, 1, 0, 0, 0, 0, "ovl_b1");
    step(0, 0, 1, 0, 0, 0, 0, "ovl_b2");
    step(0, 1, 1, 0, 0, 0, 0, "ovl_b3");
    step(0, 1, 1, 0, 1, 1, 1, "ovl_b4");
    step(0, 0, 1, 0, 0, 0, 1, "ovl_b5");
    step(0, 1, 1, 0, 0, 0, 1, "ovl_b6");
    step(0, 1, 1, 0, 1, 1, 2, "ovl_b7");

    // Non-overlapping on the same stream: only one match.
    step(1, 1, 1, 0, 0, 0, 0, "novl_b1");
    step(1, 0, 1, 0, 0, 0, 0, "novl_b2");
    step(1, 1, 1, 0, 0, 0, 0, "novl_b3");
    step(1, 1, 1, 0, 1, 1, 1, "novl_b4");
    step(1, 0, 1, 0, 0, 0, 1, "novl_b5");
    step(1, 1, 1, 0, 0, 0, 1, "novl_b6");
    step(1, 1, 1, 0, 0, 0, 1, "novl_b7");

    // Valid gating: din toggles during idle cycles and must be ignored.
    do_reset();
    step(0, 1, 1, 0, 0, 0, 0, "gate_v1");
    step(0, 0, 0, 0, 0, 0, 0, "gate_idle1");
    step(0, 1, 0, 0, 0, 0, 0, "gate_idle2");
    step(0, 0, 1, 0, 0, 0, 0, "gate_v0");
    step(0, 0, 0, 0, 0, 0, 0, "gate_idle3");
    step(0, 1, 1, 0, 0, 0, 0, "gate_v1b");
    step(0, 0, 0, 0, 0, 0, 0, "gate_idle4");
    step(0, 1, 1, 0, 1, 1, 1, "gate_match");
    step(0, 0, 0, 0, 1, 0, 1, "hold_idle1");
    step(0, 1, 0, 0, 1, 0, 1, "hold_idle2");
    step(0, 0, 0, 0, 1, 0, 1, "hold_idle3");
    step(0, 0, 1, 0, 0, 0, 1, "leave_match");

    // Async reset while in MATCH clears all outputs immediately.
    do_reset();
    step(0, 1, 1, 0, 0, 0, 0, "ar_b1");
    step(0, 0, 1, 0, 0, 0, 0, "ar_b2");
    step(0, 1, 1, 0, 0, 0, 0, "ar_b3");
    step(0, 1, 1, 0, 1, 1, 1, "ar_b4");
    async_reset_check("async_rst_in_match");

    // Async reset after 101 discards progress: a following 1 does not match.
    step(0, 1, 1, 0, 0, 0, 0, "ar2_b1");
    step(0, 0, 1, 0, 0, 0, 0, "ar2_b2");
    step(0, 1, 1, 0, 0, 0, 0, "ar2_b3");
    async_reset_check("async_rst_after_101");
    step(0, 1, 1, 0, 0, 0, 0, "ar2_after");

    // clr with a valid completing bit: bit discarded, search restarts.
    step(0, 0, 1, 0, 0, 0, 0, "clr_b2");
    step(0, 1, 1, 0, 0, 0, 0, "clr_b3");
    step(0, 1, 1, 1, 0, 0, 0, "clr_b4");
    step(0, 1, 1, 0, 0, 0, 0, "clr_then1");
    step(0, 0, 1, 0, 0, 0, 0, "clr_then0");
    step(0, 1, 1, 0, 0, 0, 0, "clr_then1b");
    step(0, 1, 1, 0, 1, 1, 1, "clr_rematch");

    // clr leaves the counter alone.
    step(0, 0, 0, 1, 0, 0, 1, "clr_keeps_cnt");

    // 2-bit counter saturation over five overlapping matches.
    do_reset();
    bits16 = 16'b1011011011011011;
    dets16 = 16'b0001001001001001;
    cnt    = 0;
    for (int i = 15; i >= 0; i--) begin
      if (dets16[i] && cnt < 3) cnt++;
      step(2, bits16[i], 1, 0, dets16[i], dets16[i], cnt, "sat_stream");
    end

    // Five-bit pattern 11011 on 11011011: matches after bits 5 and 8.
    do_reset();
    bits8 = 8'b11011011;
    dets8 = 8'b00001001;
    cnt   = 0;
    for (int i = 7; i >= 0; i--) begin
      if (dets8[i]) cnt++;
      step(3, bits8[i], 1, 0, dets8[i], dets8[i], cnt, "p5_stream");
    end

    // Drain the scoreboard with a bounded wait.
    @(negedge clk);
    idle_inputs();
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
